// File: rtl/election_controller.sv
// election_controller: timed REG -> VOTE -> RESULT election FSM with per-voter registration/vote bitmaps and tallies.
// Optional macro TIE_BREAK_LOWEST_EN: on a tie, WinnerId is the lowest-index tied candidate instead of 0.
module election_controller #(
  parameter int BOX_W       = 2,
  parameter int VOTER_W     = 4,
  parameter int N_CAND      = 4,
  parameter int CAND_W      = 2,
  parameter int REG_CYCLES  = 100,
  parameter int VOTE_CYCLES = 100,
  localparam int CNT_W      = BOX_W + VOTER_W + 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [1:0]               mode,
  input  logic [BOX_W+VOTER_W-1:0] userID,
  input  logic [CAND_W-1:0]        candidate,
  output logic [BOX_W-1:0]         ballotBoxId,
  output logic [CNT_W-1:0]         numberOfRegisteredVoters,
  output logic [CNT_W-1:0]         numberOfVotesWinner,
  output logic [CAND_W-1:0]        WinnerId,
  output logic [1:0]               phase,
  output logic                     AlreadyRegistered,
  output logic                     AlreadyVoted,
  output logic                     NotRegistered,
  output logic                     VotingHasNotStarted,
  output logic                     RegistrationHasEnded,
  output logic                     InvalidCandidate,
  output logic                     Tie,
  output logic                     ResultValid
);

  localparam int ID_W   = BOX_W + VOTER_W;
  localparam int N_ID   = 2 ** ID_W;
  localparam int N_SLOT = 2 ** CAND_W;
  localparam int T_MAX  = (REG_CYCLES > VOTE_CYCLES) ? REG_CYCLES : VOTE_CYCLES;
  localparam int TMR_W  = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  typedef enum logic [1:0] {
    PH_REG    = 2'b00,
    PH_VOTE   = 2'b01,
    PH_RESULT = 2'b10
  } phase_e;

  phase_e             phase_q;
  logic [TMR_W-1:0]   tmr_q;
  logic [N_ID-1:0]    registered_q;
  logic [N_ID-1:0]    voted_q;
  logic [CNT_W-1:0]   tally_q [N_SLOT];
  logic [BOX_W-1:0]   box_q;
  logic [CNT_W-1:0]   nreg_q;
  logic [CNT_W-1:0]   nwin_q;
  logic [CAND_W-1:0]  winner_q;
  logic               already_reg_q;
  logic               already_voted_q;
  logic               not_reg_q;
  logic               vote_not_started_q;
  logic               reg_ended_q;
  logic               invalid_cand_q;
  logic               tie_q;
  logic               result_valid_q;

  logic               cand_ok_s;
  logic [CNT_W-1:0]   max_d;
  logic [CAND_W-1:0]  first_d;
  logic [CAND_W-1:0]  winner_d;
  logic [CAND_W:0]    n_max_s;
  logic               tie_d;

  assign cand_ok_s = ({1'b0, candidate} < (CAND_W+1)'(N_CAND));

  // Result evaluation over the frozen tallies: maximum, lowest index holding it, and how many share it.
  always_comb begin
    max_d   = '0;
    first_d = '0;
    n_max_s = '0;
    for (int c = 0; c < N_CAND; c++) begin
      max_d = (tally_q[c] > max_d) ? tally_q[c] : max_d;
    end
    for (int c = N_CAND - 1; c >= 0; c--) begin
      first_d = (tally_q[c] == max_d) ? CAND_W'(c) : first_d;
      n_max_s = (tally_q[c] == max_d) ? n_max_s + (CAND_W+1)'(1) : n_max_s;
    end
    tie_d = (n_max_s > (CAND_W+1)'(1));
`ifdef TIE_BREAK_LOWEST_EN
    winner_d = first_d;
`else
    winner_d = tie_d ? '0 : first_d;
`endif
  end

  // Phase sequencing, voter bookkeeping and all registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      phase_q            <= PH_REG;
      tmr_q              <= '0;
      registered_q       <= '0;
      voted_q            <= '0;
      for (int c = 0; c < N_SLOT; c++) tally_q[c] <= '0;
      box_q              <= '0;
      nreg_q             <= '0;
      nwin_q             <= '0;
      winner_q           <= '0;
      already_reg_q      <= 1'b0;
      already_voted_q    <= 1'b0;
      not_reg_q          <= 1'b0;
      vote_not_started_q <= 1'b0;
      reg_ended_q        <= 1'b0;
      invalid_cand_q     <= 1'b0;
      tie_q              <= 1'b0;
      result_valid_q     <= 1'b0;
    end else begin
      already_reg_q      <= 1'b0;
      already_voted_q    <= 1'b0;
      not_reg_q          <= 1'b0;
      vote_not_started_q <= 1'b0;
      reg_ended_q        <= 1'b0;
      invalid_cand_q     <= 1'b0;
      case (phase_q)
        PH_REG: begin
          box_q <= userID[ID_W-1:VOTER_W];
          if (tmr_q == TMR_W'(REG_CYCLES - 1)) begin
            phase_q <= PH_VOTE;
            tmr_q   <= '0;
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
          case (mode)
            2'b00: begin
              if (registered_q[userID]) begin
                already_reg_q <= 1'b1;
              end else begin
                registered_q[userID] <= 1'b1;
                nreg_q               <= nreg_q + CNT_W'(1);
              end
            end
            2'b01:   vote_not_started_q <= 1'b1;
            default: ;
          endcase
        end
        PH_VOTE: begin
          box_q <= userID[ID_W-1:VOTER_W];
          if (tmr_q == TMR_W'(VOTE_CYCLES - 1)) begin
            phase_q <= PH_RESULT;
            tmr_q   <= '0;
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
          case (mode)
            2'b00: reg_ended_q <= 1'b1;
            2'b01: begin
              if (!registered_q[userID]) begin
                not_reg_q <= 1'b1;
              end else if (voted_q[userID]) begin
                already_voted_q <= 1'b1;
              end else if (!cand_ok_s) begin
                invalid_cand_q <= 1'b1;
              end else begin
                voted_q[userID]    <= 1'b1;
                tally_q[candidate] <= tally_q[candidate] + CNT_W'(1);
              end
            end
            default: ;
          endcase
        end
        PH_RESULT: begin
          // Results latch once; the tallies cannot change afterwards anyway.
          if (!result_valid_q) begin
            nwin_q         <= max_d;
            winner_q       <= winner_d;
            tie_q          <= tie_d;
            result_valid_q <= 1'b1;
          end
        end
        default: begin
          phase_q <= PH_REG;
          tmr_q   <= '0;
        end
      endcase
    end
  end

  assign ballotBoxId              = box_q;
  assign numberOfRegisteredVoters = nreg_q;
  assign numberOfVotesWinner      = nwin_q;
  assign WinnerId                 = winner_q;
  assign phase                    = phase_q;
  assign AlreadyRegistered        = already_reg_q;
  assign AlreadyVoted             = already_voted_q;
  assign NotRegistered            = not_reg_q;
  assign VotingHasNotStarted      = vote_not_started_q;
  assign RegistrationHasEnded     = reg_ended_q;
  assign InvalidCandidate         = invalid_cand_q;
  assign Tie                      = tie_q;
  assign ResultValid              = result_valid_q;

endmodule
